rival_car_ctrl: RTL
===================

Name: rival_car_ctrl

Overview:
Generates and moves the opponent (rival) car on the scrolling road. It spawns a rival at a pseudo-random lane position at the top of the road, moves it down once per frame, detects overlap with the player car, and counts rivals passed. It sits directly upstream of the sprite display/mux stage: that stage consumes rival_x/rival_y/rival_on to draw the second car sprite, and uses collide to enter its COLLIDE state.

Parameters:
pixel_counter_width, 10, width of all pixel coordinates
OFFSET_BG_X, 200, left screen x of road background
OFFSET_BG_Y, 150, top screen y of road background
BG_HEIGHT, 240, road background height in pixels
ROAD_LEFT, 244, minimum legal car x (inclusive)
ROAD_RIGHT, 304, maximum legal car x (inclusive)
CAR_W, 14, car sprite width (player and rival)
CAR_H, 16, car sprite height
MAIN_CAR_Y, 300, fixed screen y of player car
STEP, 2, pixels moved down per frame_tick
SPAWN_DELAY, 60, frame_ticks between despawn and next spawn
LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
clk  input  1  system clock (100 MHz board clock)
BTNC  input  1  reset: synchronous, active-high (centre button)
frame_tick  input  1  single-cycle pulse, once per frame (end of last visible pixel)
freeze  input  1  high while display stage is in COLLIDE; halts all motion/counting
main_car_x  input  pixel_counter_width  current player car x
rival_x  output  pixel_counter_width  rival car screen x
rival_y  output  pixel_counter_width  rival car screen y
rival_on  output  1  rival currently on road, draw it
collide  output  1  sticky overlap flag
passed  output  8  rivals that left the road bottom, saturating
rand  output  8  current LFSR value

Behaviour:
- All state updates on posedge clk; all outputs registered. BTNC has priority over every other input on the same cycle.
- Reset values: state=WAIT, frame count=0, rival_x=ROAD_LEFT, rival_y=OFFSET_BG_Y, rival_on=0, collide=0, passed=0, LFSR=LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4 (x^8+x^6+x^5+x^4+1), shifts every clk except during reset; never reaches 0.
- States: WAIT, SPAWN, MOVE, HIT.
- WAIT: rival_on=0. On each frame_tick with freeze=0, count++. When count==SPAWN_DELAY-1 on a frame_tick -> SPAWN, count cleared.
- SPAWN (exactly one clk): rival_x <= ROAD_LEFT + (rand mod (ROAD_RIGHT-ROAD_LEFT+1)) (span 61 by default), rival_y <= OFFSET_BG_Y, rival_on <= 1 -> MOVE. rival_x always in [ROAD_LEFT, ROAD_RIGHT].
- MOVE: on frame_tick with freeze=0: y_new = rival_y + STEP.
  - If y_new + CAR_H > OFFSET_BG_Y + BG_HEIGHT (default y_new > 374): rival_on <= 0, passed <= passed+1 (holds at 255), -> WAIT. rival_y not updated.
  - Else rival_y <= y_new; if overlap(rival_x, y_new, main_car_x) -> HIT, collide <= 1.
  - overlap = (rival_x < main_car_x+CAR_W) and (main_car_x < rival_x+CAR_W) and (y_new < MAIN_CAR_Y+CAR_H) and (MAIN_CAR_Y < y_new+CAR_H). Strict inequalities: touching edges is not a collision.
- Overlap is also evaluated on every non-tick cycle in MOVE (player may steer into a stationary rival): overlap with current rival_y -> HIT, collide=1, in the next cycle.
- HIT: rival_on stays 1, position frozen, collide held 1; left only by BTNC.
- freeze=1: frame_ticks ignored in all states (no move, no count); overlap check still active.
- Arithmetic in pixel_counter_width+1 bits to avoid wrap on sums; no coordinate output ever exceeds 639.
- Latency: rival_y changes 1 clk after the sampled frame_tick; collide rises 1 clk after the overlapping position is registered or main_car_x changes into overlap.

Test Plan:
- Reset: hold BTNC 3 clks -> rival_on=0, collide=0, passed=0, rand=8'hA5; release; LFSR sequence non-zero for 255 clks, repeats at 255.
- Spawn timing: 59 frame_ticks -> still WAIT; 60th -> within 2 clks rival_on=1, rival_y=150, 244<=rival_x<=304.
- Descent/pass: main_car_x far (e.g. rival at 244, main at 290), 112 frame_ticks -> rival_y=374; next tick -> rival_on=0, passed=1; 60 more ticks -> new spawn.
- Collision: force rival_x=270 spawn path, main_car_x=270; tick until y_new=286 -> collide=1, state HIT; further ticks leave rival_y=286; edge case main_car_x=284 (touching) -> no collide.
- Freeze: in MOVE, freeze=1 for 10 frame_ticks -> rival_y unchanged; freeze=0 -> motion resumes by STEP=2.
- Reset mid-descent/HIT: BTNC during MOVE with rival_y=220 or during HIT -> next clk all reset values; BTNC coincident with frame_tick -> reset wins, no movement.

Source files
------------

// File: rtl/rival_car_ctrl.sv
// Opponent car generator: spawns a rival at a pseudo-random lane x, scrolls it down
// once per frame, flags overlap with the player car and counts rivals that got past.
module rival_car_ctrl #(
  parameter int         pixel_counter_width = 10,
  parameter int         OFFSET_BG_X         = 200,
  parameter int         OFFSET_BG_Y         = 150,
  parameter int         BG_HEIGHT           = 240,
  parameter int         ROAD_LEFT           = 244,
  parameter int         ROAD_RIGHT          = 304,
  parameter int         CAR_W               = 14,
  parameter int         CAR_H               = 16,
  parameter int         MAIN_CAR_Y          = 300,
  parameter int         STEP                = 2,
  parameter int         SPAWN_DELAY         = 60,
  parameter logic [7:0] LFSR_SEED           = 8'hA5
) (
  input  logic                           clk,
  input  logic                           BTNC,
  input  logic                           frame_tick,
  input  logic                           freeze,
  input  logic [pixel_counter_width-1:0] main_car_x,
  output logic [pixel_counter_width-1:0] rival_x,
  output logic [pixel_counter_width-1:0] rival_y,
  output logic                           rival_on,
  output logic                           collide,
  output logic [7:0]                     passed,
  output logic [7:0]                     rand_val
);

  localparam int W    = pixel_counter_width;
  localparam int SPAN = ROAD_RIGHT - ROAD_LEFT + 1;

  // Sums are formed one bit wider than the coordinates so they never wrap.
  localparam logic [W:0] CW     = (W+1)'(CAR_W);
  localparam logic [W:0] CH     = (W+1)'(CAR_H);
  localparam logic [W:0] MY     = (W+1)'(MAIN_CAR_Y);
  localparam logic [W:0] BOTTOM = (W+1)'(OFFSET_BG_Y + BG_HEIGHT);
  localparam logic [7:0] LAST   = 8'(SPAWN_DELAY - 1);

  typedef enum logic [1:0] {WAIT, SPAWN, MOVE, HIT} state_t;

  state_t     state;
  logic [7:0] count;
  logic       tick;
  logic       feedback;
  logic [7:0] rand_mod;
  logic [W:0] y_new;
  logic       hit_new;
  logic       hit_cur;

  // Strict comparisons: boxes that only share an edge do not collide.
  function automatic logic overlap(input logic [W:0] rx, input logic [W:0] ry,
                                   input logic [W:0] mx);
    return (rx < mx + CW) && (mx < rx + CW) && (ry < MY + CH) && (MY < ry + CH);
  endfunction

  assign tick     = frame_tick & ~freeze;
  assign feedback = rand_val[7] ^ rand_val[5] ^ rand_val[4] ^ rand_val[3];
  assign rand_mod = rand_val % 8'(SPAN);
  assign y_new    = {1'b0, rival_y} + (W+1)'(STEP);
  assign hit_new  = overlap({1'b0, rival_x}, y_new, {1'b0, main_car_x});
  assign hit_cur  = overlap({1'b0, rival_x}, {1'b0, rival_y}, {1'b0, main_car_x});

  always_ff @(posedge clk) begin
    if (BTNC) rand_val <= LFSR_SEED;
    else      rand_val <= {rand_val[6:0], feedback};
  end

  always_ff @(posedge clk) begin
    if (BTNC) begin
      state    <= WAIT;
      count    <= 8'd0;
      rival_x  <= W'(ROAD_LEFT);
      rival_y  <= W'(OFFSET_BG_Y);
      rival_on <= 1'b0;
      collide  <= 1'b0;
      passed   <= 8'd0;
    end else begin
      case (state)
        WAIT: begin
          rival_on <= 1'b0;
          if (tick) begin
            if (count == LAST) begin
              count <= 8'd0;
              state <= SPAWN;
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        SPAWN: begin
          rival_x  <= W'(ROAD_LEFT) + W'(rand_mod);
          rival_y  <= W'(OFFSET_BG_Y);
          rival_on <= 1'b1;
          state    <= MOVE;
        end
        MOVE: begin
          if (tick) begin
            if (y_new + CH > BOTTOM) begin
              rival_on <= 1'b0;
              if (passed != 8'hFF) passed <= passed + 8'd1;
              state <= WAIT;
            end else begin
              rival_y <= y_new[W-1:0];
              if (hit_new) begin
                collide <= 1'b1;
                state   <= HIT;
              end
            end
          end else if (hit_cur) begin
            // Player steered into a rival that has not moved this cycle.
            collide <= 1'b1;
            state   <= HIT;
          end
        end
        HIT: begin
          rival_on <= 1'b1;
          collide  <= 1'b1;
        end
        default: state <= WAIT;
      endcase
    end
  end

endmodule
